// File: rtl/control_word_sequencer_pkg.sv
// rtl/control_word_sequencer_pkg.sv - shared control word layout, NOP word and encodings
//
// Purpose: single source for the 33-bit control word bit map used by the
// sequencer and by the decoder banks that produce the words.
// Ports: none (package).
package control_word_sequencer_pkg;

    localparam int CW_W    = 33;
    localparam int STATE_W = 2;
    localparam int K_W     = 64;

    // Bit positions inside a control word
    localparam int CW_RSVD       = 32;
    localparam int CW_ALU_EN     = 31;
    localparam int CW_ALU_BS     = 30;
    localparam int CW_ALU_FS_LSB = 25;
    localparam int CW_RF_B_EN    = 24;
    localparam int CW_RF_SA_LSB  = 19;
    localparam int CW_RF_SB_LSB  = 14;
    localparam int CW_RF_DA_LSB  = 9;
    localparam int CW_RF_W       = 8;
    localparam int CW_RAM_EN     = 7;
    localparam int CW_RAM_W      = 6;
    localparam int CW_PC_FS_LSB  = 4;
    localparam int CW_PC_IS      = 3;
    localparam int CW_STATUS_LD  = 2;
    localparam int CW_NS_LSB     = 0;

    // ALU function select encodings (low three bits of alu_fs)
    typedef enum logic [2:0] {
        ALU_AND   = 3'b000,
        ALU_OR    = 3'b001,
        ALU_ADD   = 3'b010,
        ALU_XOR   = 3'b011,
        ALU_LEFT  = 3'b100,
        ALU_RIGHT = 3'b101
    } alu_op_e;

    typedef enum logic [STATE_W-1:0] {
        ST_0 = 2'd0,
        ST_1 = 2'd1,
        ST_2 = 2'd2,
        ST_3 = 2'd3
    } seq_state_e;

    // Datapath control fields, in the same order as cw[31:2]
    typedef struct packed {
        logic       alu_en;
        logic       alu_bs;
        logic [4:0] alu_fs;
        logic       rf_b_en;
        logic [4:0] rf_sa;
        logic [4:0] rf_sb;
        logic [4:0] rf_da;
        logic       rf_w;
        logic       ram_en;
        logic       ram_w;
        logic [1:0] pc_fs;
        logic       pc_is;
        logic       status_ld;
    } cw_ctrl_t;

    typedef struct packed {
        cw_ctrl_t              ctrl;
        logic [STATE_W-1:0]    next_state;
    } cw_fields_t;

    // NOP: everything off, PC hold, register selects parked on 31 (XZR)
    localparam logic [CW_W-1:0] CW_NOP   = 33'h0_00FF_FE00;
    localparam cw_ctrl_t        CTRL_NOP = cw_ctrl_t'(CW_NOP[CW_ALU_EN:CW_STATUS_LD]);

endpackage

// File: rtl/control_word_sequencer_unpack.sv
// rtl/control_word_sequencer_unpack.sv - combinational slicer of a control word into named fields
//
// Purpose: split a CW_W control word into datapath fields and next_state.
// Ports:
//   cw     in  CW_W  raw control word
//   fields out       unpacked fields (reserved bit dropped)
module cw_field_unpack
    import control_word_sequencer_pkg::*;
(
    input  logic [CW_W-1:0] cw,
    output cw_fields_t      fields
);

    // Reserved bit carries no meaning; kept visible only so it is clearly consumed.
    logic unused_reserved;
    assign unused_reserved = cw[CW_RSVD];

    always_comb begin
        fields                = '0;
        fields.ctrl.alu_en    = cw[CW_ALU_EN];
        fields.ctrl.alu_bs    = cw[CW_ALU_BS];
        fields.ctrl.alu_fs    = cw[CW_ALU_FS_LSB +: 5];
        fields.ctrl.rf_b_en   = cw[CW_RF_B_EN];
        fields.ctrl.rf_sa     = cw[CW_RF_SA_LSB +: 5];
        fields.ctrl.rf_sb     = cw[CW_RF_SB_LSB +: 5];
        fields.ctrl.rf_da     = cw[CW_RF_DA_LSB +: 5];
        fields.ctrl.rf_w      = cw[CW_RF_W];
        fields.ctrl.ram_en    = cw[CW_RAM_EN];
        fields.ctrl.ram_w     = cw[CW_RAM_W];
        fields.ctrl.pc_fs     = cw[CW_PC_FS_LSB +: 2];
        fields.ctrl.pc_is     = cw[CW_PC_IS];
        fields.ctrl.status_ld = cw[CW_STATUS_LD];
        fields.next_state     = cw[CW_NS_LSB +: STATE_W];
    end

endmodule

// File: rtl/control_word_sequencer.sv
// rtl/control_word_sequencer.sv - registers decoder control words and sequences multi-cycle instructions
//
// Purpose: presents the instruction word and state to the decoder bank,
// registers the returned control word into datapath fields plus K, and
// follows next_state with a watchdog bounding non-zero-state runs.
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   instr_in/instr_valid    fetched instruction; instr_ack accepts it (comb)
//   ir, state               word and state presented to the decoders
//   cw_in, k_in             selected control word and constant from decoders
//   alu_*, rf_*, ram_*, pc_*, status_ld, k   registered datapath controls
//   seq_error               one-cycle pulse when the watchdog aborts a sequence
module control_word_sequencer #(
    parameter int MAX_SEQ = 4,
    parameter int CW_W    = 33
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     instr_in,
    input  logic            instr_valid,
    output logic            instr_ack,
    output logic [31:0]     ir,
    output logic [1:0]      state,
    input  logic [CW_W-1:0] cw_in,
    input  logic [63:0]     k_in,
    output logic            alu_en,
    output logic            alu_bs,
    output logic [4:0]      alu_fs,
    output logic            rf_b_en,
    output logic [4:0]      rf_sa,
    output logic [4:0]      rf_sb,
    output logic [4:0]      rf_da,
    output logic            rf_w,
    output logic            ram_en,
    output logic            ram_w,
    output logic [1:0]      pc_fs,
    output logic            pc_is,
    output logic            status_ld,
    output logic [63:0]     k,
    output logic            seq_error
);
    import control_word_sequencer_pkg::*;

    localparam int CNT_W = $clog2(MAX_SEQ + 1);

    cw_fields_t       cw_flds;
    seq_state_e       state_q, state_d;
    logic [31:0]      ir_reg_q, ir_reg_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d, wd_next;
    cw_ctrl_t         ctrl_q, ctrl_d;
    logic [63:0]      k_q, k_d;
    logic             seq_error_q, seq_error_d;

    cw_field_unpack u_unpack (
        .cw     (cw_in),
        .fields (cw_flds)
    );

    assign wd_next = wd_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        ir_reg_d    = ir_reg_q;
        wd_cnt_d    = wd_cnt_q;
        ctrl_d      = CTRL_NOP;
        k_d         = '0;
        seq_error_d = 1'b0;

        if (state_q == ST_0 && !instr_valid) begin
            // Fetch bubble: idle with NOP, keep the last instruction word
            state_d  = ST_0;
            wd_cnt_d = '0;
        end else begin
            if (state_q == ST_0) begin
                ir_reg_d = instr_in;
            end
            if (cw_flds.next_state == '0) begin
                state_d  = ST_0;
                wd_cnt_d = '0;
                ctrl_d   = cw_flds.ctrl;
                k_d      = k_in;
            end else if (wd_next == CNT_W'(MAX_SEQ)) begin
                // Runaway sequence: drop this word and return to fetch
                state_d     = ST_0;
                wd_cnt_d    = '0;
                seq_error_d = 1'b1;
            end else begin
                state_d  = seq_state_e'(cw_flds.next_state);
                wd_cnt_d = wd_next;
                ctrl_d   = cw_flds.ctrl;
                k_d      = k_in;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_0;
            ir_reg_q    <= '0;
            wd_cnt_q    <= '0;
            ctrl_q      <= CTRL_NOP;
            k_q         <= '0;
            seq_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_reg_q    <= ir_reg_d;
            wd_cnt_q    <= wd_cnt_d;
            ctrl_q      <= ctrl_d;
            k_q         <= k_d;
            seq_error_q <= seq_error_d;
        end
    end

    // Acceptance is masked during reset so nothing is consumed before release
    assign instr_ack = (state_q == ST_0) && instr_valid && !reset;
    assign ir        = (state_q == ST_0) ? instr_in : ir_reg_q;
    assign state     = state_q;

    assign alu_en    = ctrl_q.alu_en;
    assign alu_bs    = ctrl_q.alu_bs;
    assign alu_fs    = ctrl_q.alu_fs;
    assign rf_b_en   = ctrl_q.rf_b_en;
    assign rf_sa     = ctrl_q.rf_sa;
    assign rf_sb     = ctrl_q.rf_sb;
    assign rf_da     = ctrl_q.rf_da;
    assign rf_w      = ctrl_q.rf_w;
    assign ram_en    = ctrl_q.ram_en;
    assign ram_w     = ctrl_q.ram_w;
    assign pc_fs     = ctrl_q.pc_fs;
    assign pc_is     = ctrl_q.pc_is;
    assign status_ld = ctrl_q.status_ld;
    assign k         = k_q;
    assign seq_error = seq_error_q;

endmodule
